// File: rtl/tlp_xcvr_pkg.sv
// Shared types and constants for the PCIe transceiver: action records from the
// receive FSM and the completion header builder used on the transmit side.
package tlp_xcvr_pkg;

    typedef logic [3:0]  ExtChan;
    typedef logic [15:0] BusID;
    typedef logic [7:0]  Tag;
    typedef logic [63:0] uint64;

    typedef enum logic {
        ACT_REG_READ  = 1'b0,
        ACT_REG_WRITE = 1'b1
    } ActType;

    typedef struct packed {
        ActType      typ;
        ExtChan      chan;
        logic [31:0] data;
        BusID        reqID;
        Tag          tag;
    } Action;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_CPL0  = 3'd3,
        S_CPL1  = 3'd4,
        S_CPL2  = 3'd5
    } CplState;

    // fmt 3DW-with-data, type CplD, TC0, no TD/EP, length 1 DW
    localparam logic [31:0] CPL_DW0        = 32'h4A00_0001;
    localparam logic [2:0]  CPL_STATUS_SC  = 3'b000;
    localparam logic [11:0] CPL_BYTE_COUNT = 12'd4;
    localparam logic [31:0] RD_TIMEOUT_DAT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [63:0] dw10;
        logic [31:0] dw2;
    } CplHdr;

    function automatic CplHdr genCplHdr(input BusID completerID, input BusID reqID,
                                        input Tag tag, input ExtChan chan);
        CplHdr h;
        h.dw10 = {completerID, CPL_STATUS_SC, 1'b0, CPL_BYTE_COUNT, CPL_DW0};
        h.dw2  = {reqID, tag, 1'b0, {chan, 3'b000}};
        return h;
    endfunction

endpackage

// File: rtl/tlp_cpl_send.sv
// Consumes register actions: writes go straight to the application port, reads are
// answered with a 1-DW Completion-with-Data on the 64-bit Avalon-ST TX interface.
//
// state   | meaning
// S_IDLE  | wait for an action; pop and latch it
// S_WRITE | register write held until the application accepts
// S_READ  | register read pending; counts towards the read timeout
// S_CPL0  | TX beat {DW1,DW0}, SOP
// S_CPL1  | TX beat {pad,DW2}
// S_CPL2  | TX beat {pad,data}, EOP
module tlp_cpl_send
    import tlp_xcvr_pkg::*;
#(
    parameter int RD_TIMEOUT = 255
) (
    input  logic        pcieClk_in,
    input  logic        pcieReset_in,
    input  logic [12:0] cfgBusDev_in,
    input  Action       actData_in,
    input  logic        actValid_in,
    output logic        actReady_out,
    output ExtChan      cpuChan_out,
    output logic [31:0] cpuWrData_out,
    output logic        cpuWrValid_out,
    input  logic        cpuWrReady_in,
    output logic        cpuRdReq_out,
    input  logic [31:0] cpuRdData_in,
    input  logic        cpuRdValid_in,
    output uint64       txData_out,
    output logic        txValid_out,
    input  logic        txReady_in,
    output logic        txSOP_out,
    output logic        txEOP_out
);

    localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

    CplState     state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    ExtChan      chan_q, chan_d;
    logic [31:0] data_q, data_d;
    BusID        req_id_q, req_id_d;
    Tag          tag_q, tag_d;
    CplHdr       cpl_hdr;

    assign cpl_hdr       = genCplHdr({cfgBusDev_in, 3'b000}, req_id_q, tag_q, chan_q);
    assign cpuChan_out   = chan_q;
    assign cpuWrData_out = data_q;

    always_ff @(posedge pcieClk_in) begin
        if (pcieReset_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            chan_q   <= '0;
            data_q   <= '0;
            req_id_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            chan_q   <= chan_d;
            data_q   <= data_d;
            req_id_q <= req_id_d;
            tag_q    <= tag_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        chan_d         = chan_q;
        data_d         = data_q;
        req_id_d       = req_id_q;
        tag_d          = tag_q;
        actReady_out   = 1'b0;
        cpuWrValid_out = 1'b0;
        cpuRdReq_out   = 1'b0;
        txValid_out    = 1'b0;
        txSOP_out      = 1'b0;
        txEOP_out      = 1'b0;
        txData_out     = '0;

        case (state_q)
            S_IDLE: begin
                if (actValid_in) begin
                    actReady_out = 1'b1;
                    chan_d       = actData_in.chan;
                    data_d       = actData_in.data;
                    req_id_d     = actData_in.reqID;
                    tag_d        = actData_in.tag;
                    if (actData_in.typ == ACT_REG_WRITE) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                        cnt_d   = '0;
                    end
                end
            end
            S_WRITE: begin
                cpuWrValid_out = 1'b1;
                if (cpuWrReady_in) state_d = S_IDLE;
            end
            S_READ: begin
                cpuRdReq_out = 1'b1;
                cnt_d        = cnt_q + 8'd1;
                // real data wins over a timeout in the same cycle
                if (cpuRdValid_in) begin
                    data_d  = cpuRdData_in;
                    state_d = S_CPL0;
                end else if (cnt_q == TO_LAST) begin
                    data_d  = RD_TIMEOUT_DAT;
                    state_d = S_CPL0;
                end
            end
            S_CPL0: begin
                txValid_out = 1'b1;
                txSOP_out   = 1'b1;
                txData_out  = cpl_hdr.dw10;
                if (txReady_in) state_d = S_CPL1;
            end
            S_CPL1: begin
                txValid_out = 1'b1;
                txData_out  = {32'h0, cpl_hdr.dw2};
                if (txReady_in) state_d = S_CPL2;
            end
            S_CPL2: begin
                txValid_out = 1'b1;
                txEOP_out   = 1'b1;
                txData_out  = {32'h0, data_q};
                if (txReady_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pcieReset_in) begin
            actReady_out   = 1'b0;
            cpuWrValid_out = 1'b0;
            cpuRdReq_out   = 1'b0;
            txValid_out    = 1'b0;
            txSOP_out      = 1'b0;
            txEOP_out      = 1'b0;
            txData_out     = '0;
        end
    end

endmodule
